// File: rtl/eeprom_wr_pkg.sv
// rtl/eeprom_wr_pkg.sv - shared types and constants for the eeprom_wr I2C master
// Contents: FSM state enum, SCL quarter-bit phase enum, control-byte constants
// and a helper that assembles the EEPROM control byte.
package eeprom_wr_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CTRL_W,
        ACK_C,
        ADDR,
        ACK_A,
        WDATA,
        ACK_D,
        RSTART,
        CTRL_R,
        ACK_R,
        RDATA,
        MNACK,
        STOP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        P0,
        P1,
        P2,
        P3
    } phase_e;

    localparam logic [3:0] CTRL_PREFIX = 4'b1010;
    localparam logic       RW_WRITE    = 1'b0;
    localparam logic       RW_READ     = 1'b1;

    // Control byte: device prefix, the three block-select address bits, R/W.
    function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rw);
        return {CTRL_PREFIX, blk, rw};
    endfunction

endpackage

// File: rtl/eeprom_wr_if.sv
// rtl/eeprom_wr_if.sv - request/done handshake between system controller and eeprom_wr
// Signals: wr_req/rd_req (start pulses), addr[10:0], wdata[7:0] toward the master;
// rdata[7:0], busy, done, nack_err back to the controller.
// Modports: master = system-side controller, slave = eeprom_wr.
interface eeprom_wr_if;

    logic        wr_req;
    logic        rd_req;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        nack_err;

    modport master (
        output wr_req, rd_req, addr, wdata,
        input  rdata, busy, done, nack_err
    );

    modport slave (
        input  wr_req, rd_req, addr, wdata,
        output rdata, busy, done, nack_err
    );

endinterface

// File: rtl/eeprom_wr_phase_gen.sv
// rtl/eeprom_wr_phase_gen.sv - SCL quarter-bit phase generator (module i2c_phase_gen)
// Ports: clk, rst_n (async active-low), en (high while a transaction runs),
// phase_tick (one-cycle pulse on the last clk of each phase), phase (P0..P3).
// Parameter CLK_DIV: clk cycles per phase, >= 2.
module i2c_phase_gen
    import eeprom_wr_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output logic   phase_tick,
    output phase_e phase
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    phase_e        phase_q;

    assign phase_tick = en && (cnt_q == CW'(CLK_DIV - 1));
    assign phase      = phase_q;

    // Held at the start of P0 while disabled so every transaction begins
    // on a clean bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= P0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= P0;
        end else if (phase_tick) begin
            cnt_q   <= '0;
            phase_q <= phase_e'(phase_q + 2'd1);
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/eeprom_wr.sv
// rtl/eeprom_wr.sv - I2C master for single-byte random write/read of a 2 Kbyte EEPROM
// Ports: clk, rst_n (async active-low), host (eeprom_wr_if.slave handshake),
// scl (push-pull clock), sda (open-drain data, driven 0 or z only).
// Parameter CLK_DIV: clk cycles per SCL quarter-bit phase (bit time = 4*CLK_DIV).
// Macro EEPROM_WR_ACK_CHECK_EN: when defined, a NACK in any slave ACK slot
// aborts to STOP and raises nack_err; otherwise ACK slots are clocked but ignored.
module eeprom_wr
    import eeprom_wr_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    eeprom_wr_if.slave host,
    output logic       scl,
    inout  wire        sda
);

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        sda_smp_q;

    logic        phase_tick;
    phase_e      phase;
    logic        bit_end;
    logic        nack_hit;
    logic        scl_c;
    logic        sda_low;

    i2c_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q != IDLE),
        .phase_tick (phase_tick),
        .phase      (phase)
    );

    assign bit_end = phase_tick && (phase == P3);

`ifdef EEPROM_WR_ACK_CHECK_EN
    assign nack_hit = sda_smp_q;
`else
    // nack_q can then never be set, so nack_err stays at 0.
    assign nack_hit = 1'b0;
`endif

    // Bus value captured at the P1->P2 boundary, i.e. mid-way through SCL high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_smp_q <= 1'b1;
        end else if (phase_tick && (phase == P1)) begin
            sda_smp_q <= sda;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;

        case (state_q)
            IDLE: begin
                // Write wins when both requests arrive together.
                if (host.wr_req || host.rd_req) begin
                    state_d = START;
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                    is_rd_d = !host.wr_req;
                    nack_d  = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = CTRL_W;
                    shreg_d   = ctrl_byte(addr_q[10:8], RW_WRITE);
                    bit_cnt_d = '0;
                end
            end

            CTRL_W, ADDR, WDATA, CTRL_R: begin
                if (bit_end) begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            CTRL_W:  state_d = ACK_C;
                            ADDR:    state_d = ACK_A;
                            WDATA:   state_d = ACK_D;
                            default: state_d = ACK_R;
                        endcase
                    end
                end
            end

            ACK_C: begin
                if (bit_end) begin
                    if (nack_hit) begin
                        state_d = STOP;
                        nack_d  = 1'b1;
                    end else begin
                        state_d   = ADDR;
                        shreg_d   = addr_q[7:0];
                        bit_cnt_d = '0;
                    end
                end
            end

            ACK_A: begin
                if (bit_end) begin
                    if (nack_hit) begin
                        state_d = STOP;
                        nack_d  = 1'b1;
                    end else if (is_rd_q) begin
                        state_d = RSTART;
                    end else begin
                        state_d   = WDATA;
                        shreg_d   = wdata_q;
                        bit_cnt_d = '0;
                    end
                end
            end

            ACK_D: begin
                if (bit_end) begin
                    state_d = STOP;
                    nack_d  = nack_hit;
                end
            end

            RSTART: begin
                if (bit_end) begin
                    state_d   = CTRL_R;
                    shreg_d   = ctrl_byte(addr_q[10:8], RW_READ);
                    bit_cnt_d = '0;
                end
            end

            ACK_R: begin
                if (bit_end) begin
                    if (nack_hit) begin
                        state_d = STOP;
                        nack_d  = 1'b1;
                    end else begin
                        state_d   = RDATA;
                        bit_cnt_d = '0;
                    end
                end
            end

            RDATA: begin
                if (bit_end) begin
                    shreg_d   = {shreg_q[6:0], sda_smp_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = MNACK;
                    end
                end
            end

            MNACK: begin
                if (bit_end) begin
                    rdata_d = shreg_q;
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus drive. SCL is high in P1/P2 of every bit; data changes only in P0.
    // START/RSTART pull sda low at P2 (SCL high); STOP releases it at P2 and
    // keeps SCL high through P3 so the bus is left idle.
    always_comb begin
        scl_c   = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                scl_c   = 1'b1;
                sda_low = 1'b0;
            end
            START, RSTART: begin
                scl_c   = (phase == P1) || (phase == P2);
                sda_low = (phase == P2) || (phase == P3);
            end
            CTRL_W, ADDR, WDATA, CTRL_R: begin
                scl_c   = (phase == P1) || (phase == P2);
                sda_low = !shreg_q[7];
            end
            STOP: begin
                scl_c   = (phase != P0);
                sda_low = (phase == P0) || (phase == P1);
            end
            default: begin
                // ACK slots, RDATA and MNACK: clocked with sda released.
                scl_c   = (phase == P1) || (phase == P2);
                sda_low = 1'b0;
            end
        endcase
    end

    assign scl = scl_c;
    assign sda = sda_low ? 1'b0 : 1'bz;

    assign host.busy     = (state_q != IDLE);
    assign host.done     = (state_q == DONE);
    assign host.nack_err = nack_q;
    assign host.rdata    = rdata_q;

endmodule

// File: tb/tb_eeprom_wr.sv
// tb/tb_eeprom_wr.sv - randomized self-checking bench for eeprom_wr with an I2C EEPROM model
module tb_eeprom_wr;

    localparam int DIV   = 4;
    localparam int TOK_S = 256;
    localparam int TOK_P = 257;

    localparam int SM_IDLE = 0;
    localparam int SM_RECV = 1;
    localparam int SM_ACKP = 2;
    localparam int SM_ACK  = 3;
    localparam int SM_TX   = 4;
    localparam int SM_MACK = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eeprom_wr_if host();
    logic scl;
    wire  sda;
    logic s_low = 1'b0;

    assign sda = s_low ? 1'b0 : 1'bz;
    pullup (sda);

    eeprom_wr #(
        .CLK_DIV (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (host),
        .scl   (scl),
        .sda   (sda)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- EEPROM slave model + bus monitor ----------------
    logic        slv_rst    = 1'b1;
    logic        force_nack = 1'b0;
    int          mon_q[$];
    logic [7:0]  eep [int];
    int          sm = SM_IDLE;
    int          nb = 0;
    int          bidx = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  txsh = '0;
    logic        rw = 1'b0;
    logic [10:0] ptr = '0;
    logic        nack_now = 1'b0;
    logic        mack_last = 1'b0;
    int          mack_cnt = 0;
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;

    always @(scl or sda or slv_rst) begin
        if (slv_rst) begin
            s_low = 1'b0;
            sm    = SM_IDLE;
        end else if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b1 && sda === 1'b0) begin
            sm = SM_RECV; nb = 0; bidx = 0; s_low = 1'b0;
            mon_q.push_back(TOK_S);
        end else if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b0 && sda === 1'b1) begin
            sm = SM_IDLE; s_low = 1'b0;
            mon_q.push_back(TOK_P);
        end else if (scl_prev === 1'b0 && scl === 1'b1) begin
            case (sm)
                SM_RECV: begin
                    sh = {sh[6:0], sda};
                    nb++;
                    if (nb == 8) begin
                        mon_q.push_back(int'(sh));
                        nack_now = 1'b0;
                        if (bidx == 0) begin
                            rw = sh[0];
                            if (sh[7:4] != 4'b1010) nack_now = 1'b1;
                            else if (!sh[0]) ptr[10:8] = sh[3:1];
                        end else if (bidx == 1) begin
                            nack_now = force_nack;
                            if (!force_nack) ptr[7:0] = sh;
                        end else begin
                            eep[int'(ptr)] = sh;
                            ptr++;
                        end
                        sm = SM_ACKP;
                    end
                end
                SM_TX: begin
                    nb++;
                    if (nb == 8) sm = SM_MACK;
                end
                SM_MACK: begin
                    mack_last = sda;
                    mack_cnt++;
                    sm = SM_IDLE;
                end
                default: ;
            endcase
        end else if (scl_prev === 1'b1 && scl === 1'b0) begin
            case (sm)
                SM_ACKP: begin
                    s_low = !nack_now;
                    sm    = SM_ACK;
                end
                SM_ACK: begin
                    s_low = 1'b0;
                    bidx++;
                    nb = 0;
                    if (nack_now) begin
                        sm = SM_IDLE;
                    end else if (rw) begin
                        txsh  = eep.exists(int'(ptr)) ? eep[int'(ptr)] : 8'hFF;
                        ptr++;
                        s_low = !txsh[7];
                        sm    = SM_TX;
                    end else begin
                        sm = SM_RECV;
                    end
                end
                SM_TX:   s_low = !txsh[3'(7 - nb)];
                SM_MACK: s_low = 1'b0;
                default: ;
            endcase
        end
        scl_prev = scl;
        sda_prev = sda;
    end

    int done_cnt = 0;
    always @(negedge clk) begin
        if (host.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [int];
    logic [7:0] exp_rdata = 8'h00;

    function automatic logic [7:0] ref_read(input logic [10:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'hFF;
    endfunction

    task automatic run_txn(input bit rd, input bit both, input logic [10:0] a,
                           input logic [7:0] d, input bit poke, input bit fnack);
        int mark, d0, m0, n, exp_lat;
        bit eff_rd, exp_nack, timed_out;
        int exp_q[$];
        eff_rd   = rd && !both;
        mark     = mon_q.size();
        d0       = done_cnt;
        m0       = mack_cnt;
        exp_nack = 1'b0;
        force_nack = fnack;

        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({4'b1010, a[10:8], 1'b0}));
        exp_q.push_back(int'(a[7:0]));
        if (fnack) begin
            // Slave stops listening after refusing the address byte.
            exp_q.push_back(TOK_P);
`ifdef EEPROM_WR_ACK_CHECK_EN
            exp_lat  = 20 * 4 * DIV + 1;
            exp_nack = 1'b1;
`else
            exp_lat  = (eff_rd ? 156 : 116) * DIV + 1;
`endif
        end else if (eff_rd) begin
            exp_q.push_back(TOK_S);
            exp_q.push_back(int'({4'b1010, a[10:8], 1'b1}));
            exp_q.push_back(TOK_P);
            exp_lat   = 156 * DIV + 1;
            exp_rdata = ref_read(a);
        end else begin
            exp_q.push_back(int'(d));
            exp_q.push_back(TOK_P);
            exp_lat = 116 * DIV + 1;
            ref_mem[int'(a)] = d;
        end

        @(posedge clk); #1;
        host.addr   = a;
        host.wdata  = d;
        host.wr_req = !rd || both;
        host.rd_req = rd || both;
        @(posedge clk); #1;
        host.wr_req = 1'b0;
        host.rd_req = 1'b0;
        host.addr   = 11'($urandom);
        host.wdata  = 8'($urandom);
        check("busy_rise", host.busy, 1);
        check("nack_clear", host.nack_err, 0);

        n = 0;
        timed_out = 1'b1;
        while (n < 200 * DIV) begin
            if (host.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
            n++;
            host.rd_req = poke && (n == 30 * DIV);
        end
        host.rd_req = 1'b0;
        check("timeout", timed_out, 0);
        check("latency", n + 1, exp_lat);
        check("nack_err", host.nack_err, exp_nack);
        check("rdata", host.rdata, exp_rdata);
        @(posedge clk); #1;
        check("busy_fall", host.busy, 0);
        check("done_pulse", host.done, 0);
        repeat (4 * DIV) @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("nack_hold", host.nack_err, exp_nack);
        check("trace_len", mon_q.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (mark + i < mon_q.size()) check("trace", mon_q[mark + i], exp_q[i]);
        end
        if (eff_rd && !fnack) begin
            check("mnack_count", mack_cnt - m0, 1);
            check("mnack_level", mack_last, 1);
        end
        force_nack = 1'b0;
    endtask

    logic [10:0] pool [4];

    initial begin
        host.wr_req = 1'b0;
        host.rd_req = 1'b0;
        host.addr   = '0;
        host.wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", host.busy, 0);
        check("rst_done", host.done, 0);
        check("rst_nack", host.nack_err, 0);
        check("rst_rdata", host.rdata, 8'h00);
        rst_n   = 1'b1;
        slv_rst = 1'b0;

        run_txn(1'b0, 1'b0, 11'h5A3, 8'hC7, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 11'h5A3, 8'h00, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 11'h123, 8'h5E, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 11'h7FF, 8'h81, 1'b1, 1'b0);
`ifdef EEPROM_WR_ACK_CHECK_EN
        run_txn(1'b1, 1'b0, 11'h5A3, 8'h00, 1'b0, 1'b1);
`else
        run_txn(1'b0, 1'b0, 11'h5A3, 8'h11, 1'b0, 1'b1);
`endif
        run_txn(1'b1, 1'b0, 11'h123, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of the read data byte.
        @(posedge clk); #1;
        host.addr   = 11'h5A3;
        host.rd_req = 1'b1;
        @(posedge clk); #1;
        host.rd_req = 1'b0;
        repeat (31 * 4 * DIV) @(posedge clk);
        @(negedge clk); #1;
        rst_n   = 1'b0;
        slv_rst = 1'b1;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", host.busy, 0);
        check("mid_rst_done", host.done, 0);
        check("mid_rst_rdata", host.rdata, 8'h00);
        exp_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        slv_rst = 1'b0;
        run_txn(1'b0, 1'b0, 11'h000, 8'h3C, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) pool[i] = 11'($urandom);
        for (int i = 0; i < 18; i++) begin
            run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    pool[$urandom_range(0, 3)], 8'($urandom),
                    ($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eeprom_wr.md
# eeprom_wr

Synthesizable I2C master that performs single-byte random writes and random reads on the 2 Kbyte serial EEPROM (11-bit address, control byte 1010_AAA_R/W). It sits directly upstream of the EEPROM, driving `scl` and the shared open-drain `sda`, and presents a simple request/done handshake to the system-side controller. Each request is one complete bus transaction framed by START and STOP.

## Interface
- `CLK_DIV`, default 25: `clk` cycles per SCL quarter-bit phase; one bit time is 4×`CLK_DIV` cycles; legal range ≥2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_req` in 1: one-cycle pulse that starts a write; sampled only when idle.
- `rd_req` in 1: one-cycle pulse that starts a read; sampled only when idle.
- `addr` in 11: byte address, latched on acceptance.
- `wdata` in 8: write data, latched on acceptance.
- `rdata` out 8: read data; updated only when a read completes.
- `busy` out 1: high from the accept cycle through the `done` cycle.
- `done` out 1: one-cycle pulse at transaction end, whether successful or aborted.
- `nack_err` out 1: high with `done` when the slave NACKed; held until the next accept.
- `scl` out 1: I2C clock, push-pull.
- `sda` inout 1: I2C data; the block drives only 0 or z (open-drain).

## Operation
- Control byte is {4'b1010, addr[10:8], R/W}; the address byte is addr[7:0]. Bits are sent MSB first.
- **Write sequence:** START, ctrl(W), ACK, addr byte, ACK, data, ACK, STOP.
- **Read sequence:** START, ctrl(W), ACK, addr byte, ACK, repeated START, ctrl(R), ACK, 8 data bits driven by the slave, master NACK (sda released), STOP.
- **FSM states:** IDLE, START, CTRL_W, ACK_C, ADDR, ACK_A, WDATA, ACK_D, RSTART, CTRL_R, ACK_R, RDATA, MNACK, STOP, DONE.
- **Transition order:**
  - Write path: IDLE→START→CTRL_W→ACK_C→ADDR→ACK_A→WDATA→ACK_D→STOP→DONE→IDLE.
  - Read path: ACK_A branches to RSTART→CTRL_R→ACK_R→RDATA→MNACK→STOP.
- **Simultaneous requests:** if `wr_req` and `rd_req` are high in the same idle cycle, the write is accepted and the read is dropped.
- **Requests while busy** are ignored; they are not queued.
- A 3-bit counter tracks the bit within the byte; the shift register is 8 bits.
- `rdata` is loaded from the shift register in the MNACK state; a write or an aborted read leaves it unchanged.

## Timing
- **Bit phases (each lasts `CLK_DIV` cycles):**
  - P0: SCL low; sda is updated.
  - P1: SCL high.
  - P2: SCL high; sda is sampled at the start of this phase.
  - P3: SCL low.
- START: sda high→low at P1/P2 boundary while SCL high. STOP: sda low→high at P1/P2 boundary while SCL high. RSTART: sda released in P0, then falls while SCL high.
- **Latency from the accept cycle to `done`:**
  - Write: 29 bit times (1+27+1), i.e. 116×`CLK_DIV` cycles, +1 cycle.
  - Read: 39 bit times, i.e. 156×`CLK_DIV` cycles, +1 cycle.
- `busy` rises in the cycle after the request and falls in the cycle after `done`.
- **Reset values:** scl=1, sda=z, busy=0, done=0, nack_err=0, rdata=8'h00, state=IDLE.
- **Reset mid-transaction:** outputs return to their reset values immediately and asynchronously; no STOP is issued. The next transaction's START resynchronizes the slave.
- The bus idles with scl=1 and sda=z whenever the FSM is in IDLE.

## Configuration
- `EEPROM_WR_ACK_CHECK_EN` defined:
  - sda is sampled at P2 of every ACK slot.
  - A 1 (NACK) aborts the transaction: go to STOP, then DONE, with `nack_err`=1.
- `EEPROM_WR_ACK_CHECK_EN` undefined:
  - ACK slots are still clocked with sda released, but the sampled value is not checked.
  - `nack_err` is tied to 0 and the full sequence always runs.

## Structure
- Package `eeprom_wr_pkg` holds:
  - the FSM state enum;
  - `CTRL_PREFIX` = 4'b1010;
  - `RW_WRITE`/`RW_READ` bit constants;
  - the phase enum P0..P3.
- One sub-module, `i2c_phase_gen`: a `CLK_DIV` counter that emits a one-cycle `phase_tick` and the current 2-bit phase. It is enabled only while busy and cleared in IDLE.

## Test plan
- **Write:** `wr_req` with addr=11'h5A3, wdata=8'hC7 → bus carries ctrl 8'hAA, addr 8'hA3, data 8'hC7 with STOP; EEPROM model holds mem[0x5A3]=8'hC7; `done` arrives 116×`CLK_DIV`+1 cycles after accept.
- **Read-back:** after the write, `rd_req` with addr=11'h5A3 → repeated START then ctrl 8'hAB; `rdata`=8'hC7 and `nack_err`=0 at `done`.
- **Simultaneous requests:** `wr_req` and `rd_req` in the same idle cycle → write performed, no read issued, exactly one `done`.
- **Request while busy:** `rd_req` mid-write → ignored; one `done`; `rdata` unchanged.
- **NACK (with `EEPROM_WR_ACK_CHECK_EN`):** slave forced to NACK the addr byte → STOP issued immediately; `done` with `nack_err`=1; `rdata` unchanged.
- **Reset mid-read:** `rst_n` low during RDATA → scl=1, sda=z, busy=0 immediately; a following write to 11'h000 with 8'h3C completes correctly.
